// File: rtl/imm_extend_unit.sv
// Registered immediate extender with a 2-entry valid/ready output buffer.
// Extends a raw immediate (sign, zero, shifted branch offset, upper placement) into an operand.
module imm_extend_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg
);

    // state | meaning
    // EMPTY | no result buffered
    // ONE   | head entry valid
    // FULL  | head and tail valid, input stalled
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    generate
        if (OUT_W < IN_W + SHIFT) begin : g_bad_width
            $error("imm_extend_unit: OUT_W must be >= IN_W + SHIFT");
        end
    endgenerate

    logic [1:0]       state;
    logic [OUT_W-1:0] head_data;
    logic [OUT_W-1:0] tail_data;
    logic             head_neg;
    logic             tail_neg;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    logic             push;
    logic             pop;

    always_comb begin
        sext = OUT_W'(signed'(in_data));
        case (in_mode)
            2'b00:   ext = sext;
            2'b01:   ext = OUT_W'(in_data);
            2'b10:   ext = sext << SHIFT;
            default: ext = OUT_W'(in_data) << (OUT_W - IN_W);
        endcase
    end

    // in_ready depends only on the state register, never on out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = head_data;
    assign out_neg   = head_neg;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            head_data <= '0;
            tail_data <= '0;
            head_neg  <= 1'b0;
            tail_neg  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_data <= ext;
                        head_neg  <= ext[OUT_W-1];
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_data <= ext;
                        head_neg  <= ext[OUT_W-1];
                    end else if (push) begin
                        tail_data <= ext;
                        tail_neg  <= ext[OUT_W-1];
                        state     <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_data <= tail_data;
                        head_neg  <= tail_neg;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed and randomised checks of imm_extend_unit against a queue-based scoreboard.
module tb_imm_extend_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_neg;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    logic [31:0] sb[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    logic [15:0] vec_data [6] = '{16'hFFDB, 16'hFFDB, 16'hFFDB, 16'hFFDB, 16'h7FFF, 16'h7FFF};
    logic [1:0]  vec_mode [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
    logic [31:0] vec_exp  [6] = '{32'hFFFFFFDB, 32'h0000FFDB, 32'hFFFFFF6C, 32'hFFDB0000,
                                  32'h00007FFF, 32'h0001FFFC};
    logic        vec_neg  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    imm_extend_unit #(.IN_W(16), .OUT_W(32), .SHIFT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_neg   (out_neg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
        logic [31:0] s;
        s = {{16{d[15]}}, d};
        case (m)
            2'b00:   return s;
            2'b01:   return {16'h0000, d};
            2'b10:   return {s[29:0], 2'b00};
            default: return {d, 16'h0000};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, update the scoreboard, return just after the rising edge.
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("out_valid_vs_occupancy", 32'(out_valid), 32'(sb.size() != 0));
            check("in_ready_vs_occupancy", 32'(in_ready), 32'(sb.size() < 2));
            if (prev_stall)
                check("stall_stable", out_data, prev_data);
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", out_data, e);
                check("out_neg", 32'(out_neg), 32'(e[31]));
                n_out++;
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_data, in_mode));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int target;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_neg", 32'(out_neg), 0);
        check("reset_in_ready", 32'(in_ready), 1);

        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = vec_data[i];
            in_mode  = vec_mode[i];
            step();
            check("mode_valid", 32'(out_valid), 1);
            check("mode_data", out_data, vec_exp[i]);
            check("mode_neg", 32'(out_neg), 32'(vec_neg[i]));
        end
        in_valid = 1'b0;
        step();

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_data   = 16'h0001;
        step();
        in_data = 16'h0002;
        step();
        check("bp_in_ready_full", 32'(in_ready), 0);
        in_data = 16'h0003;
        step();
        check("bp_third_held", 32'(in_ready), 0);
        check("bp_head_first", out_data, 32'h1);
        out_ready = 1'b1;
        step();
        check("bp_in_ready_rise", 32'(in_ready), 1);
        check("bp_head_second", out_data, 32'h2);
        step();
        check("bp_head_third", out_data, 32'h3);
        in_valid = 1'b0;
        step();
        check("bp_drained", 32'(out_valid), 0);

        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_mode   = 2'b01;
        for (int d = 16'h10; d <= 16'h1F; d++) begin
            in_data = 16'(d);
            step();
            check("stream_data", out_data, 32'(d));
            check("stream_in_ready", 32'(in_ready), 1);
        end
        in_valid = 1'b0;
        step();

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_data   = 16'h00AA;
        step();
        in_data = 16'h00BB;
        step();
        check("rst_pre_full", 32'(in_ready), 0);
        rst     = 1'b1;
        in_data = 16'hBEEF;
        step();
        sb.delete();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_mid_out_valid", 32'(out_valid), 0);
        check("rst_mid_out_data", out_data, 0);
        check("rst_mid_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        repeat (3) step();

        cyc    = 0;
        target = n_out + 1000;
        while (n_out < target && cyc < 20000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            in_mode   = 2'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        check("random_transfers", 32'(n_out), 32'(target));

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check("drain_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
